// File: rtl/note_seq_pkg.sv
// Shared state encoding, default widths and ROM word layout for the note sequencer.
package note_seq_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int SEL_W_DEF   = 2;
    localparam int NOTE_W_DEF  = 6;
    localparam int DUR_W_DEF   = 6;
    localparam int ROM_LAT_DEF = 2;

    // ROM word is {note, duration}; duration occupies the low bits.
    localparam int DUR_LSB   = 0;
    localparam int REST_NOTE = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/note_dur_counter.sv
// Beat-driven duration down-counter; expire_o marks the beat that consumes the final count.
module note_dur_counter #(
    parameter int DUR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             beat_i,
    output logic             expire_o
);

    logic [DUR_W-1:0] cnt_q;
    logic [DUR_W-1:0] cnt_d;

    // Next count: clear beats load, load beats a beat decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {DUR_W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (beat_i && (cnt_q != {DUR_W{1'b0}})) begin
            cnt_d = cnt_q - DUR_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {DUR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = beat_i && (cnt_q == DUR_W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Song ROM sequencer: fetches {note, duration} words and times each note in beats.
// Build option NOTE_SEQ_LOOP_EN: at end of song, restart from word 0 without waiting for new_note.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int NOTE_W  = NOTE_W_DEF,
    parameter int DUR_W   = DUR_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SEL_W-1:0]        song_sel,
    input  logic                    new_note,
    input  logic                    beat,
    output logic [SEL_W+ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_valid,
    output logic                    note_done,
    output logic                    song_done,
    output logic                    busy
);

    localparam int RA_W     = SEL_W + ADDR_W;
    localparam int LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int NOTE_LSB = DUR_LSB + DUR_W;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0]  word_addr_q, word_addr_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               addr_wait_q, addr_wait_d;
    logic [RA_W-1:0]    rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic               note_valid_q, note_valid_d;
    logic               note_done_q, note_done_d;
    logic               song_done_q, song_done_d;
    logic               busy_q, busy_d;

    logic [NOTE_W-1:0]  rom_note_s;
    logic [DUR_W-1:0]   rom_dur_s;
    logic               cnt_load_s, cnt_clear_s, cnt_beat_s, cnt_expire_s;
    logic               pause_s, eos_s, start_fetch_s;

    assign rom_note_s = rom_data[NOTE_LSB +: NOTE_W];
    assign rom_dur_s  = rom_data[DUR_LSB +: DUR_W];
    assign cnt_beat_s = (state_q == ST_PLAY) && play && beat;

    note_dur_counter #(
        .DUR_W (DUR_W)
    ) u_dur_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (cnt_clear_s),
        .load_i     (cnt_load_s),
        .load_val_i (rom_dur_s),
        .beat_i     (cnt_beat_s),
        .expire_o   (cnt_expire_s)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        word_addr_d   = word_addr_q;
        lat_cnt_d     = lat_cnt_q;
        addr_wait_d   = addr_wait_q;
        note_d        = note_q;
        note_valid_d  = 1'b0;
        note_done_d   = 1'b0;
        song_done_d   = 1'b0;
        cnt_load_s    = 1'b0;
        pause_s       = 1'b0;
        eos_s         = 1'b0;
        start_fetch_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (song_sel != sel_q) begin
                    sel_d       = song_sel;
                    word_addr_d = {ADDR_W{1'b0}};
                end else begin
                    sel_d = sel_q;
                end
                if (new_note && play) begin
                    state_d       = ST_FETCH;
                    start_fetch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!play) begin
                    pause_s = 1'b1;
                end else if (addr_wait_q) begin
                    addr_wait_d = 1'b0;
                end else if (lat_cnt_q == LAT_LAST) begin
                    if (rom_dur_s == {DUR_W{1'b0}}) begin
                        eos_s = 1'b1;
                    end else begin
                        note_d       = rom_note_s;
                        note_valid_d = 1'b1;
                        cnt_load_s   = 1'b1;
                        state_d      = ST_PLAY;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            ST_PLAY: begin
                if (!play) begin
                    pause_s = 1'b1;
                end else if (cnt_expire_s) begin
                    note_done_d = 1'b1;
                    word_addr_d = word_addr_q + ADDR_W'(1);
                    if (word_addr_q == {ADDR_W{1'b1}}) begin
                        eos_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_WAIT: begin
                if (!play) begin
                    pause_s = 1'b1;
                end else if (new_note) begin
                    state_d       = ST_FETCH;
                    start_fetch_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pause keeps word_addr so playback resumes by re-fetching the interrupted word.
        if (pause_s) begin
            state_d = ST_IDLE;
            note_d  = NOTE_W'(REST_NOTE);
        end else if (eos_s) begin
            song_done_d = 1'b1;
            note_d      = NOTE_W'(REST_NOTE);
            word_addr_d = {ADDR_W{1'b0}};
`ifdef NOTE_SEQ_LOOP_EN
            state_d       = ST_FETCH;
            start_fetch_s = 1'b1;
`else
            state_d = ST_IDLE;
`endif
        end else begin
            note_d = note_d;
        end

        rom_addr_d = {sel_d, word_addr_d};

        // A fetch launched together with an address change needs one extra cycle for the ROM.
        if (start_fetch_s) begin
            lat_cnt_d   = {LAT_W{1'b0}};
            addr_wait_d = (rom_addr_d != rom_addr_q);
        end else begin
            lat_cnt_d = lat_cnt_d;
        end

        busy_d = (state_d == ST_FETCH) || (state_d == ST_PLAY);
    end

    assign cnt_clear_s = pause_s;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= {SEL_W{1'b0}};
            word_addr_q  <= {ADDR_W{1'b0}};
            lat_cnt_q    <= {LAT_W{1'b0}};
            addr_wait_q  <= 1'b0;
            rom_addr_q   <= {RA_W{1'b0}};
            note_q       <= {NOTE_W{1'b0}};
            note_valid_q <= 1'b0;
            note_done_q  <= 1'b0;
            song_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            word_addr_q  <= word_addr_d;
            lat_cnt_q    <= lat_cnt_d;
            addr_wait_q  <= addr_wait_d;
            rom_addr_q   <= rom_addr_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
            note_done_q  <= note_done_d;
            song_done_q  <= song_done_d;
            busy_q       <= busy_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign note_done  = note_done_q;
    assign song_done  = song_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 2-cycle-latency song ROM model.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song_sel;
    logic        new_note;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note;
    logic        note_valid;
    logic        note_done;
    logic        song_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [0:127];
    logic [6:0]  addr_p1;
    logic [6:0]  addr_p2;

    always #5 clk = ~clk;

    // ROM: data reflects the address presented two cycles earlier.
    always @(posedge clk) begin
        addr_p1 <= rom_addr;
        addr_p2 <= addr_p1;
    end
    assign rom_data = mem[addr_p2];

    note_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .song_sel   (song_sel),
        .new_note   (new_note),
        .beat       (beat),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .note_valid (note_valid),
        .note_done  (note_done),
        .song_done  (song_done),
        .busy       (busy)
    );

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        step(1);
        beat = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset    = 1'b0;
        play     = 1'b0;
        song_sel = 2'd0;
        new_note = 1'b0;
        beat     = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 12'h000;
        mem[32] = {6'd12, 6'd3};
        mem[33] = {6'd20, 6'd4};
        mem[34] = {6'd7,  6'd0};
        for (int i = 0; i < 32; i++) mem[64 + i] = {6'(i + 1), 6'd1};

        // Reset values
        step(2);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_note", 32'(note), 32'h0);
        chk("rst_note_valid", 32'(note_valid), 32'h0);
        chk("rst_note_done", 32'(note_done), 32'h0);
        chk("rst_song_done", 32'(song_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        #3 reset = 1'b1;
        step(1);

        // Song 1, word 0 = {12, 3}
        song_sel = 2'd1;
        step(2);
        chk("sel1_addr", 32'(rom_addr), 32'h20);
        play = 1'b1;
        new_note = 1'b1;
        step(1);
        new_note = 1'b0;
        chk("w0_busy", 32'(busy), 32'h1);
        chk("w0_nv_c1", 32'(note_valid), 32'h0);
        step(1);
        chk("w0_nv_c2", 32'(note_valid), 32'h0);
        step(1);
        chk("w0_nv_c3", 32'(note_valid), 32'h1);
        chk("w0_note", 32'(note), 32'd12);
        step(1);
        chk("w0_nv_pulse", 32'(note_valid), 32'h0);
        pulse_beat();
        pulse_beat();
        chk("w0_done_early", 32'(note_done), 32'h0);
        pulse_beat();
        chk("w0_done", 32'(note_done), 32'h1);
        chk("w0_note_hold", 32'(note), 32'd12);
        chk("w0_next_addr", 32'(rom_addr), 32'h21);
        chk("w0_wait_busy", 32'(busy), 32'h0);
        step(1);
        chk("w0_done_pulse", 32'(note_done), 32'h0);

        // Word 1 = {20, 4}: pause on the 2nd beat
        new_note = 1'b1;
        step(1);
        new_note = 1'b0;
        step(2);
        chk("w1_nv", 32'(note_valid), 32'h1);
        chk("w1_note", 32'(note), 32'd20);
        pulse_beat();
        play = 1'b0;
        beat = 1'b1;
        step(1);
        beat = 1'b0;
        chk("pause_note", 32'(note), 32'h0);
        chk("pause_busy", 32'(busy), 32'h0);
        chk("pause_done", 32'(note_done), 32'h0);
        step(3);
        chk("pause_done_late", 32'(note_done), 32'h0);
        chk("pause_addr", 32'(rom_addr), 32'h21);

        // Resume: new_note and beat during FETCH are ignored
        play = 1'b1;
        new_note = 1'b1;
        step(1);
        beat = 1'b1;
        step(1);
        new_note = 1'b0;
        beat = 1'b0;
        chk("resume_nv_c2", 32'(note_valid), 32'h0);
        step(1);
        chk("resume_nv_c3", 32'(note_valid), 32'h1);
        chk("resume_note", 32'(note), 32'd20);
        new_note = 1'b1;
        pulse_beat();
        new_note = 1'b0;
        chk("play_newnote_ign", 32'(note_valid), 32'h0);
        pulse_beat();
        pulse_beat();
        chk("resume_done_early", 32'(note_done), 32'h0);
        chk("resume_busy", 32'(busy), 32'h1);
        pulse_beat();
        chk("resume_done", 32'(note_done), 32'h1);
        chk("resume_next_addr", 32'(rom_addr), 32'h22);
        step(1);

        // Word 2 has duration 0: end of song
        new_note = 1'b1;
        step(1);
        new_note = 1'b0;
        step(2);
        chk("eos_song_done", 32'(song_done), 32'h1);
        chk("eos_nv", 32'(note_valid), 32'h0);
        chk("eos_note", 32'(note), 32'h0);
        chk("eos_addr", 32'(rom_addr), 32'h20);
`ifdef NOTE_SEQ_LOOP_EN
        chk("eos_loop_busy", 32'(busy), 32'h1);
        step(2);
        chk("loop_nv_early", 32'(note_valid), 32'h0);
        step(1);
        chk("loop_nv", 32'(note_valid), 32'h1);
        chk("loop_note", 32'(note), 32'd12);
`else
        chk("eos_busy", 32'(busy), 32'h0);
        step(1);
        chk("eos_pulse", 32'(song_done), 32'h0);
`endif
        play = 1'b0;
        step(1);
        chk("stop_busy", 32'(busy), 32'h0);

        // Song 2: 32 one-beat notes, wrap at word 31
        song_sel = 2'd2;
        step(1);
        chk("sel2_addr", 32'(rom_addr), 32'h40);
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            new_note = 1'b1;
            step(1);
            new_note = 1'b0;
            step(2);
            chk("s2_nv", 32'(note_valid), 32'h1);
            chk("s2_note", 32'(note), 32'(i + 1));
            pulse_beat();
            chk("s2_done", 32'(note_done), 32'h1);
            if (i == 31) begin
                chk("wrap_song_done", 32'(song_done), 32'h1);
                chk("wrap_addr", 32'(rom_addr), 32'h40);
            end else begin
                chk("s2_song_done", 32'(song_done), 32'h0);
                chk("s2_addr", 32'(rom_addr), 32'(32'h40 + i + 1));
            end
        end
        chk("wrap_note", 32'(note), 32'h0);
`ifdef NOTE_SEQ_LOOP_EN
        chk("wrap_loop_busy", 32'(busy), 32'h1);
`else
        chk("wrap_busy", 32'(busy), 32'h0);
`endif
        play = 1'b0;
        step(1);
        play = 1'b1;

        // Asynchronous reset mid-PLAY
        new_note = 1'b1;
        step(1);
        new_note = 1'b0;
        step(2);
        chk("pre_rst_note", 32'(note), 32'd1);
        step(1);
        #3 reset = 1'b0;
        #1;
        chk("arst_note", 32'(note), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_addr", 32'(rom_addr), 32'h0);
        chk("arst_nd", 32'(note_done), 32'h0);
        step(1);
        reset = 1'b1;
        step(1);
        chk("post_rst_addr", 32'(rom_addr), 32'h40);
        chk("post_rst_busy", 32'(busy), 32'h0);
        new_note = 1'b1;
        step(1);
        new_note = 1'b0;
        step(2);
        chk("post_rst_nv", 32'(note_valid), 32'h1);
        chk("post_rst_note", 32'(note), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
